// File: rtl/sel_pkg.sv
// Shared types and defaults for the grid select path: FSM states, mode encodings
// and the default grid geometry.
package sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_ACCUM  = 1'b1;

    localparam int unsigned DEF_GRID_W = 12;
    localparam int unsigned DEF_GRID_H = 12;
    localparam int unsigned DEF_COR_W  = 4;

endpackage

// File: rtl/grid_onehot_dec.sv
// Combinational (x, y) -> one-hot decoder over a GRID_W x GRID_H grid.
// Bit index is y*GRID_W + x; out-of-range coordinates produce an all-zero vector.
module grid_onehot_dec
    import sel_pkg::*;
#(
    parameter int unsigned GRID_W = DEF_GRID_W,
    parameter int unsigned GRID_H = DEF_GRID_H,
    parameter int unsigned COR_W  = DEF_COR_W
) (
    input  logic [COR_W-1:0]         x_cor,
    input  logic [COR_W-1:0]         y_cor,
    output logic [GRID_W*GRID_H-1:0] onehot,
    output logic                     in_range
);

    localparam int unsigned N = GRID_W * GRID_H;

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] idx;

    // Widen before comparing so a grid dimension equal to 2**COR_W stays correct.
    assign x_ext    = 32'(x_cor);
    assign y_ext    = 32'(y_cor);
    assign in_range = (x_ext < GRID_W) && (y_ext < GRID_H);
    assign idx      = y_ext * GRID_W + x_ext;
    assign onehot   = in_range ? (N'(1) << idx) : '0;

endmodule

// File: rtl/grid_select_seq.sv
// Registered coordinate-to-select stage: single one-hot per coordinate, or an
// OR-accumulated mask per batch, with valid/ready on both sides and error flags.
module grid_select_seq
    import sel_pkg::*;
#(
    parameter int unsigned GRID_W = DEF_GRID_W,
    parameter int unsigned GRID_H = DEF_GRID_H,
    parameter int unsigned COR_W  = DEF_COR_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [COR_W-1:0]                       x_cor,
    input  logic [COR_W-1:0]                       y_cor,
    input  logic                                   in_last,
    input  logic                                   mode,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [GRID_W*GRID_H-1:0]               select,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0]     hit_count,
    output logic                                   oor_err,
    output logic                                   dup_err
);

    localparam int unsigned N     = GRID_W * GRID_H;
    localparam int unsigned CNT_W = $clog2(N + 1);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     select_q, select_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             oor_q, oor_d;
    logic             dup_q, dup_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             oor_acc_q, oor_acc_d;
    logic             dup_acc_q, dup_acc_d;

    logic [N-1:0]     dec_onehot;
    logic             dec_in_range;

    logic             accept;
    logic             consume;
    logic             fold;
    logic             present;

    logic [N-1:0]     base_mask;
    logic [CNT_W-1:0] base_count;
    logic             base_oor;
    logic             base_dup;
    logic             already_set;
    logic [N-1:0]     merged_mask;
    logic [CNT_W-1:0] merged_count;
    logic             merged_oor;
    logic             merged_dup;

    grid_onehot_dec #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .COR_W  (COR_W)
    ) u_dec (
        .x_cor    (x_cor),
        .y_cor    (y_cor),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // in_ready depends only on state, out_valid and out_ready.
    always_comb begin
        case (state_q)
            ACCUM:   in_ready = 1'b1;
            OUT:     in_ready = 1'b0;
            default: in_ready = !out_valid_q || out_ready;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid_q && out_ready;

    // A batch always starts from a clean accumulator, whatever the registers hold.
    assign base_mask    = (state_q == ACCUM) ? mask_q    : '0;
    assign base_count   = (state_q == ACCUM) ? count_q   : '0;
    assign base_oor     = (state_q == ACCUM) ? oor_acc_q : 1'b0;
    assign base_dup     = (state_q == ACCUM) ? dup_acc_q : 1'b0;

    assign already_set  = |(base_mask & dec_onehot);
    assign merged_mask  = base_mask | dec_onehot;
    assign merged_count = base_count + CNT_W'(dec_in_range && !already_set);
    assign merged_oor   = base_oor | !dec_in_range;
    assign merged_dup   = base_dup | already_set;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        out_valid_d = out_valid_q;
        select_d    = select_q;
        hit_count_d = hit_count_q;
        oor_d       = oor_q;
        dup_d       = dup_q;
        mask_d      = mask_q;
        count_d     = count_q;
        oor_acc_d   = oor_acc_q;
        dup_acc_d   = dup_acc_q;
        fold        = 1'b0;
        present     = 1'b0;

        case (state_q)
            IDLE: begin
                if (consume) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (mode == MODE_SINGLE) begin
                        out_valid_d = 1'b1;
                        select_d    = dec_onehot;
                        hit_count_d = CNT_W'(dec_in_range);
                        oor_d       = !dec_in_range;
                        dup_d       = 1'b0;
                    end else begin
                        fold    = 1'b1;
                        present = in_last;
                        state_d = in_last ? OUT : ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    fold    = 1'b1;
                    present = in_last;
                    if (in_last) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (consume) begin
                    out_valid_d = 1'b0;
                    mask_d      = '0;
                    count_d     = '0;
                    oor_acc_d   = 1'b0;
                    dup_acc_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fold) begin
            mask_d    = merged_mask;
            count_d   = merged_count;
            oor_acc_d = merged_oor;
            dup_acc_d = merged_dup;
        end

        // The closing coordinate is already folded into what is presented.
        if (present) begin
            out_valid_d = 1'b1;
            select_d    = merged_mask;
            hit_count_d = merged_count;
            oor_d       = merged_oor;
            dup_d       = merged_dup;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            select_q    <= '0;
            hit_count_q <= '0;
            oor_q       <= 1'b0;
            dup_q       <= 1'b0;
            mask_q      <= '0;
            count_q     <= '0;
            oor_acc_q   <= 1'b0;
            dup_acc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            select_q    <= select_d;
            hit_count_q <= hit_count_d;
            oor_q       <= oor_d;
            dup_q       <= dup_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            oor_acc_q   <= oor_acc_d;
            dup_acc_q   <= dup_acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign select    = select_q;
    assign hit_count = hit_count_q;
    assign oor_err   = oor_q;
    assign dup_err   = dup_q;

endmodule

// File: tb/tb_grid_select_seq.sv
// Self-checking bench for grid_select_seq: queue-based transaction model with a
// per-cycle compare, directed literal checks, and a 16x8 parameter instance.
module tb_grid_select_seq;

    localparam int GW  = 12;
    localparam int GH  = 12;
    localparam int N1  = GW * GH;
    localparam int CW1 = $clog2(N1 + 1);
    localparam int GW2 = 16;
    localparam int GH2 = 8;
    localparam int N2  = GW2 * GH2;
    localparam int CW2 = $clog2(N2 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     x_cor = '0;
    logic [3:0]     y_cor = '0;
    logic           in_last = 1'b0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N1-1:0]  select;
    logic [CW1-1:0] hit_count;
    logic           oor_err;
    logic           dup_err;

    logic           in_valid2 = 1'b0;
    logic           in_ready2;
    logic [3:0]     x_cor2 = '0;
    logic [3:0]     y_cor2 = '0;
    logic           out_valid2;
    logic [N2-1:0]  select2;
    logic [CW2-1:0] hit_count2;
    logic           oor_err2;
    logic           dup_err2;

    grid_select_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_cor     (x_cor),
        .y_cor     (y_cor),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .select    (select),
        .hit_count (hit_count),
        .oor_err   (oor_err),
        .dup_err   (dup_err)
    );

    grid_select_seq #(.GRID_W(GW2), .GRID_H(GH2), .COR_W(4)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .x_cor     (x_cor2),
        .y_cor     (y_cor2),
        .in_last   (1'b0),
        .mode      (1'b0),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .select    (select2),
        .hit_count (hit_count2),
        .oor_err   (oor_err2),
        .dup_err   (dup_err2)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending outputs plus the open batch, as sets of grid cells.
    typedef struct {
        logic [N1-1:0] sel;
        int            cnt;
        bit            oor;
        bit            dup;
        bit            acc;
    } txn_t;

    txn_t          q[$];
    bit            in_batch = 1'b0;
    logic [N1-1:0] bmask = '0;
    bit            boor = 1'b0;
    bit            bdup = 1'b0;

    function automatic bit exp_in_ready();
        if (in_batch)      return 1'b1;
        if (q.size() == 0) return 1'b1;
        if (q[0].acc)      return 1'b0;
        return out_ready;
    endfunction

    always @(posedge clk) begin
        bit   rdy;
        bit   rng;
        int   xi;
        int   yi;
        int   idx;
        txn_t t;
        rdy = exp_in_ready();
        if (rst) begin
            q.delete();
            in_batch = 1'b0;
            bmask    = '0;
            boor     = 1'b0;
            bdup     = 1'b0;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                xi  = int'(x_cor);
                yi  = int'(y_cor);
                rng = (xi < GW) && (yi < GH);
                idx = yi * GW + xi;
                if (!in_batch && mode == 1'b0) begin
                    t.sel = '0;
                    if (rng) t.sel[idx] = 1'b1;
                    t.cnt = $countones(t.sel);
                    t.oor = !rng;
                    t.dup = 1'b0;
                    t.acc = 1'b0;
                    q.push_back(t);
                end else begin
                    if (!in_batch) begin
                        bmask    = '0;
                        boor     = 1'b0;
                        bdup     = 1'b0;
                        in_batch = 1'b1;
                    end
                    if (rng) begin
                        if (bmask[idx]) bdup = 1'b1;
                        bmask[idx] = 1'b1;
                    end else begin
                        boor = 1'b1;
                    end
                    if (in_last) begin
                        t.sel = bmask;
                        t.cnt = $countones(bmask);
                        t.oor = boor;
                        t.dup = bdup;
                        t.acc = 1'b1;
                        q.push_back(t);
                        in_batch = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("out_valid", 256'(out_valid), 256'(q.size() != 0));
            check("in_ready", 256'(in_ready), 256'(exp_in_ready()));
            if (q.size() != 0) begin
                check("select", 256'(select), 256'(q[0].sel));
                check("hit_count", 256'(hit_count), 256'(q[0].cnt));
                check("oor_err", 256'(oor_err), 256'(q[0].oor));
                check("dup_err", 256'(dup_err), 256'(q[0].dup));
            end
        end
    end

    task automatic send(input int x, input int y, input bit m, input bit last, input bit rnd_ready);
        bit rdy;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            x_cor    = 4'(x);
            y_cor    = 4'(y);
            mode     = m;
            in_last  = last;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1 rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end
    endtask

    task automatic idle(input int n, input bit rnd_ready);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send2(input int x, input int y);
        @(negedge clk);
        in_valid2 = 1'b1;
        x_cor2    = 4'(x);
        y_cor2    = 4'(y);
        @(negedge clk);
        in_valid2 = 1'b0;
    endtask

    function automatic int rc();
        if ($urandom_range(0, 1) == 0) return $urandom_range(0, 2);
        return $urandom_range(0, 15);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N1-1:0] e;
        logic [N2-1:0] e2;

        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_select", 256'(select), 256'(0));
        check("rst_hit_count", 256'(hit_count), 256'(0));
        check("rst_flags", 256'({oor_err, dup_err}), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        rst = 1'b0;

        // Single mode corner cells
        out_ready = 1'b1;
        send(3, 2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        e = '0;
        e[27] = 1'b1;
        check("m0_3_2_select", 256'(select), 256'(e));
        check("m0_3_2_count", 256'(hit_count), 256'(1));
        check("m0_3_2_oor", 256'(oor_err), 256'(0));
        send(11, 11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        e = '0;
        e[143] = 1'b1;
        check("m0_11_11_select", 256'(select), 256'(e));

        // Out-of-range in each axis
        send(12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("oor_x_select", 256'(select), 256'(0));
        check("oor_x_count", 256'(hit_count), 256'(0));
        check("oor_x_flag", 256'(oor_err), 256'(1));
        send(0, 12, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("oor_y_select", 256'(select), 256'(0));
        check("oor_y_flag", 256'(oor_err), 256'(1));

        // Back-to-back stream, then backpressure hold
        for (int i = 0; i < 4; i++) send(i, i, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e = '0;
        e[39] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_select", 256'(select), 256'(e));
            check("hold_valid", 256'(out_valid), 256'(1));
            check("hold_in_ready", 256'(in_ready), 256'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        idle(2, 1'b0);

        // Accumulate batch with a duplicate
        send(0, 0, 1'b1, 1'b0, 1'b0);
        send(5, 1, 1'b1, 1'b0, 1'b0);
        send(5, 1, 1'b0, 1'b0, 1'b0);
        send(11, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        e = '0;
        e[0]  = 1'b1;
        e[17] = 1'b1;
        e[11] = 1'b1;
        check("acc_select", 256'(select), 256'(e));
        check("acc_count", 256'(hit_count), 256'(3));
        check("acc_dup", 256'(dup_err), 256'(1));
        check("acc_oor", 256'(oor_err), 256'(0));
        check("acc_in_ready", 256'(in_ready), 256'(0));
        @(negedge clk);
        out_ready = 1'b1;
        idle(2, 1'b0);

        // Reset mid-batch discards the partial mask
        send(2, 2, 1'b1, 1'b0, 1'b0);
        send(3, 3, 1'b1, 1'b0, 1'b0);
        send(4, 4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", 256'(out_valid), 256'(0));
        check("midrst_select", 256'(select), 256'(0));
        check("midrst_count", 256'(hit_count), 256'(0));
        send(1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        e = '0;
        e[1] = 1'b1;
        check("post_rst_select", 256'(select), 256'(e));
        check("post_rst_flags", 256'({oor_err, dup_err}), 256'(0));

        // 16x8 instance
        check("p2_in_ready", 256'(in_ready2), 256'(1));
        send2(15, 7);
        e2 = '0;
        e2[127] = 1'b1;
        check("p2_15_7_select", 256'(select2), 256'(e2));
        check("p2_15_7_count", 256'(hit_count2), 256'(1));
        send2(15, 0);
        e2 = '0;
        e2[15] = 1'b1;
        check("p2_15_0_select", 256'(select2), 256'(e2));
        send2(0, 8);
        check("p2_0_8_oor", 256'(oor_err2), 256'(1));
        check("p2_0_8_select", 256'(select2), 256'(0));
        check("p2_valid", 256'({out_valid2, dup_err2}), 256'(2));

        // Randomized mixed traffic against the model
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                send(rc(), rc(), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                int len;
                len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++)
                    send(rc(), rc(), (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), k == len - 1, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
